// File: rtl/imem_program_loader.sv
// imem_program_loader: receives a framed byte stream (16-bit word count, then
// little-endian 32-bit instruction words), writes the words into instruction
// memory from address 0 upward, and holds the core in reset until loading ends.
module imem_program_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_BYTES,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q,  state_d;
  logic [7:0]            n_lo_q,   n_lo_d;
  logic [ADDR_WIDTH-1:0] last_q,   last_d;   // word index of the final word (N-1)
  logic [ADDR_WIDTH-1:0] word_q,   word_d;
  logic [1:0]            byte_q,   byte_d;
  logic [23:0]           lanes_q,  lanes_d;  // first three bytes of the word in progress
  logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
  logic [31:0]           wdata_q,  wdata_d;

  logic        accept;
  logic [15:0] n_full;

  assign accept     = in_valid & in_ready;
  assign n_full     = {in_data, n_lo_q};
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    n_lo_d     = n_lo_q;
    last_d     = last_q;
    word_d     = word_q;
    byte_d     = byte_q;
    lanes_d    = lanes_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    cpu_hold   = 1'b1;
    load_done  = 1'b0;
    load_error = 1'b0;

    case (state_q)
      S_CNT_LO: begin
        in_ready = 1'b1;
        if (accept) begin
          n_lo_d  = in_data;
          state_d = S_CNT_HI;
        end
      end

      S_CNT_HI: begin
        in_ready = 1'b1;
        if (accept) begin
          if (n_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, n_full} > 17'(DEPTH)) begin
            state_d = S_ERROR;
          end else begin
            // N == DEPTH truncates to all-ones, i.e. the last address, so no wrap.
            last_d  = ADDR_WIDTH'(n_full - 16'd1);
            word_d  = '0;
            byte_d  = 2'd0;
            state_d = S_BYTES;
          end
        end
      end

      S_BYTES: begin
        in_ready = 1'b1;
        if (accept) begin
          byte_d = byte_q + 2'd1;
          case (byte_q)
            2'd0: lanes_d[7:0]   = in_data;
            2'd1: lanes_d[15:8]  = in_data;
            2'd2: lanes_d[23:16] = in_data;
            default: begin
              wdata_d = {in_data, lanes_q};
              addr_d  = word_q;
              state_d = S_WRITE;
            end
          endcase
        end
      end

      S_WRITE: begin
        imem_we = 1'b1;
        if (word_q == last_q) begin
          state_d = S_DONE;
        end else begin
          word_d  = word_q + ADDR_WIDTH'(1);
          state_d = S_BYTES;
        end
      end

      S_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (start) state_d = S_CNT_LO;
      end

      S_ERROR: begin
        load_error = 1'b1;
        if (start) state_d = S_CNT_LO;
      end

      default: state_d = S_CNT_LO;
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CNT_LO;
      n_lo_q  <= '0;
      last_q  <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      lanes_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_lo_q  <= n_lo_d;
      last_q  <= last_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      lanes_q <= lanes_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: a frame model predicts the write
// sequence, the driver streams bytes with random gaps, a monitor checks writes.
module tb_imem_program_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_error;

  int checks = 0;
  int errors = 0;

  int unsigned exp_addr[$];
  logic [31:0] exp_data[$];

  imem_program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Monitor: every write strobe must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h with nothing expected",
                 imem_addr, imem_wdata);
      end else begin
        int unsigned a;
        logic [31:0] d;
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        check("write_addr", {{(32-AW){1'b0}}, imem_addr}, a);
        check("write_data", imem_wdata, d);
      end
    end
  end

  initial begin
    #3000000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    summary_and_finish();
  end

  // Drives bytes one at a time; each byte is offered until it is accepted.
  // Returns right after the rising edge that accepted the last byte.
  task automatic send_bytes(input logic [7:0] b[$], input int pct);
    foreach (b[i]) begin
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        if ($urandom_range(99) < pct) begin
          in_valid = 1'b1;
          in_data  = b[i];
        end else begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
        end
        start = ($urandom_range(9) == 0);
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        guard++;
        if (!acc && guard > 200) begin
          checks++;
          errors++;
          $display("FAIL byte_accept_timeout: byte %0d not accepted in 200 cycles", i);
          summary_and_finish();
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag, input bit done, input bit err);
    check({tag, "_load_done"},  load_done,  done);
    check({tag, "_load_error"}, load_error, err);
    check({tag, "_cpu_hold"},   cpu_hold,   !done);
    check({tag, "_in_ready"},   in_ready,   1'b0);
    check({tag, "_imem_we"},    imem_we,    1'b0);
  endtask

  // Builds the frame for N words, records predicted writes, sends it and
  // checks the completion timing and final status.
  task automatic run_frame(input logic [31:0] w[$], input int unsigned n, input int pct);
    logic [7:0]  b[$];
    logic [15:0] n16;
    n16 = n[15:0];
    b.push_back(n16[7:0]);
    b.push_back(n16[15:8]);
    if (n >= 1 && n <= DEPTH) begin
      for (int k = 0; k < int'(n); k++) begin
        logic [31:0] word;
        word = w[k];
        b.push_back(word[7:0]);
        b.push_back(word[15:8]);
        b.push_back(word[23:16]);
        b.push_back(word[31:24]);
        exp_addr.push_back(k);
        exp_data.push_back(word);
      end
    end
    send_bytes(b, pct);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    #1;
    if (n == 0) begin
      check_idle_outputs("zero", 1'b1, 1'b0);
    end else if (n > DEPTH) begin
      check_idle_outputs("err", 1'b0, 1'b1);
    end else begin
      check("we_after_last_byte", imem_we, 1'b1);
      @(negedge clk);
      #1;
      check_idle_outputs("done", 1'b1, 1'b0);
      check("addr_hold",  {{(32-AW){1'b0}}, imem_addr}, n - 1);
      check("wdata_hold", imem_wdata, w[n-1]);
    end
    repeat (3) @(negedge clk);
    #1;
    check("pending_writes", exp_addr.size(), 0);
    check("status_stable_done",  load_done,  (n >= 1 && n <= DEPTH) || n == 0);
    check("status_stable_error", load_error, n > DEPTH);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("restart_in_ready",   in_ready,   1'b1);
    check("restart_cpu_hold",   cpu_hold,   1'b1);
    check("restart_load_done",  load_done,  1'b0);
    check("restart_load_error", load_error, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   in_ready,   1'b1);
    check({tag, "_imem_we"},    imem_we,    1'b0);
    check({tag, "_imem_addr"},  {{(32-AW){1'b0}}, imem_addr}, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'h0);
    check({tag, "_cpu_hold"},   cpu_hold,   1'b1);
    check({tag, "_load_done"},  load_done,  1'b0);
    check({tag, "_load_error"}, load_error, 1'b0);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] empty[$];
    logic [7:0]  part[$];

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    // Two-word program at full rate.
    w = '{32'h00500093, 32'h00A00113};
    run_frame(w, 2, 100);

    // Empty program.
    do_start();
    run_frame(empty, 0, 100);

    // Oversize count, then re-arm from ERROR.
    do_start();
    run_frame(empty, 65, 100);
    do_start();
    // Count whose low byte alone would look legal.
    run_frame(empty, 256, 100);
    do_start();

    // Full memory: N equal to depth.
    w.delete();
    for (int k = 0; k < DEPTH; k++) w.push_back(32'h00000013 + k);
    run_frame(w, DEPTH, 100);

    // First program again with a throttled source.
    do_start();
    w = '{32'h00500093, 32'h00A00113};
    run_frame(w, 2, 50);

    // Reset in the middle of the first word, then a one-word program.
    do_start();
    part = '{8'h02, 8'h00, 8'h93, 8'h00};
    send_bytes(part, 100);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    w = '{32'h000000EF};
    run_frame(w, 1, 100);

    // Randomized frames.
    for (int it = 0; it < 8; it++) begin
      int unsigned n;
      do_start();
      w.delete();
      if ($urandom_range(3) == 0) begin
        n = DEPTH + 1 + $urandom_range(65535 - DEPTH - 1);
      end else begin
        n = 1 + $urandom_range(7);
        for (int k = 0; k < int'(n); k++) w.push_back($urandom);
      end
      run_frame(w, n, 30 + $urandom_range(70));
    end

    summary_and_finish();
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction memory that the fetch/decode path reads.
- Accepts a framed byte stream over a valid/ready handshake, packs the bytes into 32-bit little-endian RV32I instruction words, and writes them sequentially into instruction memory from word address 0.
- Holds the processor core in reset until the whole program is written.
- Flags an error if the frame is larger than the memory.

Parameters:
- ADDR_WIDTH, 6, instruction-memory word-address width; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; re-arms the loader from DONE or ERROR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  high keeps the core in reset.
- load_done  output  1  program fully written.
- load_error  output  1  frame word count exceeded depth.

Behaviour:
- Interface: one clock domain (clk); reset is synchronous and active-high.
- Byte accepted on a rising edge only when in_valid & in_ready. in_data is ignored otherwise.
- Frame format: 2-byte word count N (low byte first), then 4*N instruction bytes. Each word is little-endian: first byte goes to [7:0], fourth byte to [31:24].
- States:
  - CNT_LO: in_ready=1. On accept, latch N[7:0] and go to CNT_HI.
  - CNT_HI: in_ready=1. On accept, latch N[15:8], then:
    - N==0: go to DONE.
    - N > 2**ADDR_WIDTH: go to ERROR.
    - Otherwise: go to BYTES, with byte index 0 and word index 0.
  - BYTES: in_ready=1. Each accept shifts the byte into its lane and increments the 2-bit byte index. On the 4th accept, go to WRITE.
  - WRITE: lasts exactly one cycle; in_ready=0.
    - imem_we=1, imem_addr = word index, imem_wdata = assembled word (registered outputs).
    - Next state: DONE if word index == N-1; else BYTES with word index+1.
  - DONE: in_ready=0, load_done=1, cpu_hold=0.
  - ERROR: in_ready=0, load_error=1, cpu_hold=1.
- Restart: start in DONE or ERROR goes to CNT_LO. The next cycle has cpu_hold=1 and load_done=load_error=0. start is ignored in all other states.
- Timing:
  - Write latency: imem_we is high in the cycle immediately after the edge that accepted the 4th byte.
  - Minimum of 5 cycles per word at full in_valid rate.
  - load_done rises and cpu_hold falls in the cycle after the last WRITE cycle.
- in_valid low mid-word: the loader stalls in BYTES. Partial-word bytes and the byte index are preserved, with no timeout.
- Bytes arriving while in_ready=0 are not consumed. The source must hold them.
- Write path:
  - imem_we is never high outside WRITE.
  - imem_addr and imem_wdata hold their last values when imem_we=0.
  - N == 2**ADDR_WIDTH is legal: the last write goes to address 2**ADDR_WIDTH-1, with no wrap.
- Reset values: state CNT_LO, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, load_done=0, load_error=0. Byte index, word index and N are all cleared.
- Reset mid-frame, including during WRITE: the next cycle returns to the reset values. Partial data is discarded, and no write is issued in the cycle after reset.

Test Plan:
- Reset, then stream 02 00 | 93 00 50 00 | 13 01 A0 00 with in_valid held high -> two imem_we pulses: addr 0 data 0x00500093, then addr 1 data 0x00A00113. load_done=1 and cpu_hold=0 one cycle after the second pulse; in_ready=0 in DONE.
- Stream 00 00 -> DONE directly, with no imem_we pulse; cpu_hold falls the cycle after the second byte is accepted.
- ADDR_WIDTH=6, stream 41 00 (N=65) -> load_error=1, cpu_hold stays 1, in_ready=0, no writes. Then a start pulse -> CNT_LO, load_error=0, in_ready=1.
- N=64 with word k = 0x00000013+k -> 64 writes; last write at addr 63 with data 0x00000052; load_done=1.
- Toggle in_valid randomly (50%) on the frame from the first scenario -> identical write sequence and data; no byte is lost or duplicated while in_ready=0.
- Assert reset after the 2nd instruction byte, then send 01 00 EF 00 00 00 -> a single write at addr 0 with data 0x000000EF; earlier partial bytes are absent.
